// File: rtl/tank_input_ctrl.sv
// Keyboard-to-tank command translator: decodes four HID keycodes into frame-aligned
// movement levels, edge-detected cooldown-limited fire pulses and a restart pulse.
module tank_input_ctrl #(
    parameter int unsigned COOLDOWN_FRAMES = 30
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] keycode,
    input  logic        frame_tick,
    input  logic        game_active,
    output logic [3:0]  p1_move,
    output logic        p1_fire,
    output logic [3:0]  p2_move,
    output logic        p2_fire,
    output logic        restart
);

    localparam int unsigned CD_W    = $clog2(COOLDOWN_FRAMES + 1);
    localparam int unsigned KEYS    = 11;
    localparam int unsigned SLOTS   = 4;
    localparam int unsigned PLAYERS = 2;
    localparam int unsigned ENTER   = 10;
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_FRAMES);

    // Per player, bits [4:0] are {fire, fwd, back, rot_l, rot_r}; player 2 sits 5 bits up
    localparam logic [7:0] KEY_CODE [KEYS] = '{
        8'h07, 8'h04, 8'h16, 8'h1A, 8'h14,
        8'h0F, 8'h0D, 8'h0E, 8'h0C, 8'h18,
        8'h28
    };

    logic [KEYS-1:0]    cur_q, cur_d;
    logic [3:0]         move_q [PLAYERS];
    logic [3:0]         move_d [PLAYERS];
    logic [PLAYERS-1:0] fire_q, fire_d;
    logic [PLAYERS-1:0] prev_fire_q, prev_fire_d;
    logic [CD_W-1:0]    cd_q [PLAYERS];
    logic [CD_W-1:0]    cd_d [PLAYERS];
    logic               enter_q, enter_d;
    logic               restart_q, restart_d;

    // Opposing directions on one axis cancel each other
    function automatic logic [3:0] resolve(input logic [3:0] m);
        resolve = {m[3] & ~m[2], m[2] & ~m[3], m[1] & ~m[0], m[0] & ~m[1]};
    endfunction

    always_comb begin
        cur_d = '0;
        for (int k = 0; k < KEYS; k++) begin
            for (int s = 0; s < SLOTS; s++) begin
                if (keycode[8*s +: 8] == KEY_CODE[k]) begin
                    cur_d[k] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        logic elig;
        for (int p = 0; p < PLAYERS; p++) begin
            move_d[p]      = move_q[p];
            fire_d[p]      = 1'b0;
            prev_fire_d[p] = prev_fire_q[p];
            cd_d[p]        = cd_q[p];
            elig = frame_tick & game_active & cur_q[5*p + 4] & ~prev_fire_q[p]
                 & (cd_q[p] == '0);
            if (frame_tick) begin
                move_d[p]      = resolve(cur_q[5*p +: 4]);
                prev_fire_d[p] = cur_q[5*p + 4];
                if (elig) begin
                    fire_d[p] = 1'b1;
                    cd_d[p]   = CD_LOAD;
                end else if (cd_q[p] != '0) begin
                    cd_d[p] = cd_q[p] - CD_W'(1);
                end
            end
            if (!game_active) begin
                move_d[p] = '0;
                cd_d[p]   = '0;
            end
        end
        enter_d   = cur_q[ENTER];
        restart_d = cur_q[ENTER] & ~enter_q;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cur_q       <= '0;
            fire_q      <= '0;
            prev_fire_q <= '0;
            enter_q     <= 1'b0;
            restart_q   <= 1'b0;
            for (int p = 0; p < PLAYERS; p++) begin
                move_q[p] <= '0;
                cd_q[p]   <= '0;
            end
        end else begin
            cur_q       <= cur_d;
            fire_q      <= fire_d;
            prev_fire_q <= prev_fire_d;
            enter_q     <= enter_d;
            restart_q   <= restart_d;
            for (int p = 0; p < PLAYERS; p++) begin
                move_q[p] <= move_d[p];
                cd_q[p]   <= cd_d[p];
            end
        end
    end

    assign p1_move = move_q[0];
    assign p1_fire = fire_q[0];
    assign p2_move = move_q[1];
    assign p2_fire = fire_q[1];
    assign restart = restart_q;

endmodule

// File: tb/tb_tank_input_ctrl.sv
// Scoreboard bench for tank_input_ctrl: a key-set / tick-deadline reference model
// predicts every output cycle; a monitor pops predictions and compares.
module tb_tank_input_ctrl;

    localparam int COOL = 30;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] keycode = '0;
    logic        frame_tick = 1'b0;
    logic        game_active = 1'b0;
    logic [3:0]  p1_move, p2_move;
    logic        p1_fire, p2_fire, restart;

    tank_input_ctrl #(.COOLDOWN_FRAMES(COOL)) dut (
        .Clk(Clk), .Reset(Reset), .keycode(keycode), .frame_tick(frame_tick),
        .game_active(game_active), .p1_move(p1_move), .p1_fire(p1_fire),
        .p2_move(p2_move), .p2_fire(p2_fire), .restart(restart)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [3:0] m1;
        logic       f1;
        logic [3:0] m2;
        logic       f2;
        logic       r;
    } out_t;

    out_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   p1_cnt  = 0;

    function automatic bit down(input logic [31:0] kc, input logic [7:0] code);
        down = (kc[7:0] == code) || (kc[15:8] == code) ||
               (kc[23:16] == code) || (kc[31:24] == code);
    endfunction

    // Reference model: key held-ness by set membership, cooldown as a tick-index deadline
    logic [31:0] m_kc = '0;
    bit          m_enter = 0;
    bit          m_prev [2] = '{0, 0};
    int          allowed [2] = '{0, 0};
    int          tcount = 0;
    out_t        last_e = '0;

    always @(posedge Clk) begin
        out_t e;
        logic [7:0] fw_c [2], bk_c [2], rl_c [2], rr_c [2], fi_c [2];
        bit fw, bk, rl, rr, fi, fire;
        logic [3:0] mv;
        fw_c = '{8'h1A, 8'h0C}; bk_c = '{8'h16, 8'h0E};
        rl_c = '{8'h04, 8'h0D}; rr_c = '{8'h07, 8'h0F}; fi_c = '{8'h14, 8'h18};
        e = last_e;
        if (Reset) begin
            e = '0;
            m_kc = '0;
            m_enter = 0;
            m_prev = '{0, 0};
            allowed = '{tcount, tcount};
        end else begin
            e.r = down(m_kc, 8'h28) && !m_enter;
            m_enter = down(m_kc, 8'h28);
            for (int p = 0; p < 2; p++) begin
                fw = down(m_kc, fw_c[p]); bk = down(m_kc, bk_c[p]);
                rl = down(m_kc, rl_c[p]); rr = down(m_kc, rr_c[p]);
                fi = down(m_kc, fi_c[p]);
                mv = (p == 0) ? e.m1 : e.m2;
                fire = 0;
                if (!game_active) begin
                    mv = '0;
                    allowed[p] = tcount;
                end else if (frame_tick) begin
                    mv = {fw && !bk, bk && !fw, rl && !rr, rr && !rl};
                    if (fi && !m_prev[p] && tcount >= allowed[p]) begin
                        fire = 1;
                        allowed[p] = tcount + COOL + 1;
                    end
                end
                if (frame_tick) m_prev[p] = fi;
                if (p == 0) begin e.m1 = mv; e.f1 = fire; end
                else begin e.m2 = mv; e.f2 = fire; end
            end
            if (frame_tick) tcount++;
            m_kc = keycode;
        end
        last_e = e;
        sb.push_back(e);
    end

    // Monitor: compare every predicted cycle, plus pulse-width sanity
    bit last_f1 = 0, last_f2 = 0, last_r = 0;
    always @(negedge Clk) begin
        out_t e, got;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            got = {p1_move, p1_fire, p2_move, p2_fire, restart};
            n_tests++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL outputs @%0t: got m1=%b f1=%b m2=%b f2=%b r=%b, want m1=%b f1=%b m2=%b f2=%b r=%b",
                         $time, got.m1, got.f1, got.m2, got.f2, got.r,
                         e.m1, e.f1, e.m2, e.f2, e.r);
            end
            n_tests++;
            if ((p1_fire === 1'b1 && last_f1) || (p2_fire === 1'b1 && last_f2) ||
                (restart === 1'b1 && last_r)) begin
                n_fail++;
                $display("FAIL pulse_width @%0t: f1=%b f2=%b r=%b high two cycles, want single-cycle",
                         $time, p1_fire, p2_fire, restart);
            end
            last_f1 = (p1_fire === 1'b1);
            last_f2 = (p2_fire === 1'b1);
            last_r  = (restart === 1'b1);
            if (p1_fire === 1'b1) p1_cnt++;
        end
    end

    task automatic cyc(input bit t);
        @(negedge Clk);
        frame_tick = t;
    endtask

    task automatic tick_gap(input int gap);
        repeat (gap) cyc(0);
        cyc(1);
    endtask

    function automatic logic [7:0] rand_code();
        case ($urandom_range(0, 13))
            0: rand_code = 8'h1A;   1: rand_code = 8'h16;   2: rand_code = 8'h04;
            3: rand_code = 8'h07;   4: rand_code = 8'h14;   5: rand_code = 8'h0C;
            6: rand_code = 8'h0E;   7: rand_code = 8'h0D;   8: rand_code = 8'h0F;
            9: rand_code = 8'h18;  10: rand_code = 8'h28;
            11: rand_code = 8'($urandom_range(0, 255));
            default: rand_code = 8'h00;
        endcase
    endfunction

    initial begin
        int c0;
        repeat (3) cyc(0);
        Reset = 1'b0;

        // Single forward key
        game_active = 1'b1;
        keycode = 32'h0000_001A;
        tick_gap(2);
        repeat (3) cyc(0);

        // W+S cancel, A kept
        keycode = 32'h0004_161A;
        tick_gap(3);
        repeat (3) cyc(0);

        // Held Q over 40 ticks fires once
        keycode = 32'h0000_0014;
        c0 = p1_cnt;
        repeat (40) tick_gap(3);
        repeat (3) cyc(0);
        n_tests++;
        if (p1_cnt - c0 != 1) begin
            n_fail++;
            $display("FAIL hold_once: got %0d p1 pulses, want 1", p1_cnt - c0);
        end

        // Re-press every other tick: cooldown spacing
        for (int i = 0; i < 70; i++) begin
            keycode = i[0] ? 32'h0 : 32'h0000_0014;
            tick_gap(3);
        end
        keycode = '0;
        repeat (40) tick_gap(3);

        // Both players on one tick, then reset mid-cooldown
        keycode = 32'h0000_1814;
        tick_gap(3);
        repeat (5) tick_gap(3);
        @(negedge Clk); Reset = 1'b1;
        @(negedge Clk); Reset = 1'b0;
        keycode = '0;
        tick_gap(3);
        keycode = 32'h0000_0014;
        tick_gap(3);
        repeat (3) cyc(0);

        // Enter with game inactive
        game_active = 1'b0;
        keycode = 32'h0000_0028;
        repeat (100) cyc($urandom_range(0, 7) == 0);
        keycode = '0;
        repeat (3) cyc(0);

        // Moves clear immediately when game ends mid-frame
        game_active = 1'b1;
        keycode = 32'h0C07_0000;
        tick_gap(3);
        repeat (2) cyc(0);
        @(negedge Clk); game_active = 1'b0;
        repeat (4) cyc(0);
        game_active = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 8000; i++) begin
            @(negedge Clk);
            frame_tick = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 5) == 0)
                keycode = {rand_code(), rand_code(), rand_code(), rand_code()};
            if (game_active && $urandom_range(0, 199) == 0) game_active = 1'b0;
            else if (!game_active && $urandom_range(0, 9) == 0) game_active = 1'b1;
            Reset = ($urandom_range(0, 799) == 0);
        end
        Reset = 1'b0;
        frame_tick = 1'b0;
        repeat (4) cyc(0);

        n_tests++;
        if (sb.size() > 2) begin
            n_fail++;
            $display("FAIL drain: got %0d pending predictions, want <= 2", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
